ssd1306_spi_rx: RTL and testbench

- SPI slave front end that emulates the SSD1306 4-wire serial interface (sclk, mosi, cs_n, dc).
- Sits directly upstream of the VGA framebuffer/scanout stage and drives its 9-bit din / din_ready write port.
- Emits display-data bytes as {1'b0, byte}.
- Parses the command stream and emits the 9'h100 frame-restart token whenever a page-address command (0x22) completes.

---
 rtl/ssd1306_pkg.sv | 59 +++++
 rtl/ssd1306_spi_rx_byte.sv | 105 ++++++++++
 rtl/ssd1306_spi_rx.sv | 129 ++++++++++++
 tb/tb_ssd1306_spi_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg
// Shared definitions for the SSD1306 serial-interface receiver:
//   - command opcodes that take trailing argument bytes
//   - arg_count(): number of argument bytes that follow a given opcode
//   - SYNC_TOKEN: framebuffer write word that restarts the frame
//   - parser_state_t: command parser states
package ssd1306_pkg;

    localparam logic [7:0] CMD_MEM_MODE     = 8'h20;
    localparam logic [7:0] CMD_COL_ADDR     = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR    = 8'h22;
    localparam logic [7:0] CMD_SCROLL_R     = 8'h26;
    localparam logic [7:0] CMD_SCROLL_L     = 8'h27;
    localparam logic [7:0] CMD_SCROLL_VR    = 8'h29;
    localparam logic [7:0] CMD_SCROLL_VL    = 8'h2A;
    localparam logic [7:0] CMD_CONTRAST     = 8'h81;
    localparam logic [7:0] CMD_CHARGE_PUMP  = 8'h8D;
    localparam logic [7:0] CMD_VSCROLL_AREA = 8'hA3;
    localparam logic [7:0] CMD_MUX_RATIO    = 8'hA8;
    localparam logic [7:0] CMD_DISP_OFFSET  = 8'hD3;
    localparam logic [7:0] CMD_CLK_DIV      = 8'hD5;
    localparam logic [7:0] CMD_PRECHARGE    = 8'hD9;
    localparam logic [7:0] CMD_COM_PINS     = 8'hDA;
    localparam logic [7:0] CMD_VCOMH        = 8'hDB;

    localparam logic [8:0] SYNC_TOKEN = 9'h100;

    typedef enum logic {
        CMD = 1'b0,
        ARG = 1'b1
    } parser_state_t;

    // Argument bytes following an opcode; 0 means a single-byte command.
    function automatic logic [2:0] arg_count(input logic [7:0] opcode);
        logic [2:0] n;
        n = 3'd0;
        case (opcode)
            CMD_PAGE_ADDR,
            CMD_COL_ADDR,
            CMD_VSCROLL_AREA: n = 3'd2;
            CMD_MEM_MODE,
            CMD_CONTRAST,
            CMD_CHARGE_PUMP,
            CMD_MUX_RATIO,
            CMD_DISP_OFFSET,
            CMD_CLK_DIV,
            CMD_PRECHARGE,
            CMD_COM_PINS,
            CMD_VCOMH:        n = 3'd1;
            CMD_SCROLL_R,
            CMD_SCROLL_L:     n = 3'd6;
            CMD_SCROLL_VR,
            CMD_SCROLL_VL:    n = 3'd5;
            default:          n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ssd1306_spi_rx_byte.sv
// spi_byte_rx
// Synchronises the asynchronous SPI pins into clk, detects rising sclk,
// assembles MSB-first bytes and reports aborted (partial) transfers.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   spi_sclk/mosi/cs_n/dc raw SPI pins (mode 0)
//   rx_byte               completed byte (valid with byte_valid)
//   rx_dc                 dc level latched with the byte
//   byte_valid            one-cycle strobe, byte complete
//   abort                 one-cycle pulse, cs_n rose mid-byte
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    input  logic       spi_dc,
    output logic [7:0] rx_byte,
    output logic       rx_dc,
    output logic       byte_valid,
    output logic       abort
);

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic [SYNC_STAGES-1:0] cs_n_sync_reg;
    logic [SYNC_STAGES-1:0] dc_sync_reg;
    logic                   sclk_prev_reg;

    logic [7:0] shift_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] rx_byte_reg;
    logic       rx_dc_reg;
    logic       byte_valid_reg;
    logic       abort_reg;

    logic       sclk_s, mosi_s, cs_n_s, dc_s;
    logic       sclk_rise;
    logic       shift_en;
    logic [7:0] shift_next;

    // All four pins are taken from the same stage so mosi/dc line up with sclk.
    assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];
    assign cs_n_s = cs_n_sync_reg[SYNC_STAGES-1];
    assign dc_s   = dc_sync_reg[SYNC_STAGES-1];

    assign sclk_rise  = sclk_s & ~sclk_prev_reg;
    // The 8th edge still completes the byte if cs_n rises in the same cycle.
    assign shift_en   = sclk_rise & (~cs_n_s | (bit_cnt_reg == 3'd7));
    assign shift_next = {shift_reg[6:0], mosi_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_reg <= '0;
            mosi_sync_reg <= '0;
            cs_n_sync_reg <= '1;
            dc_sync_reg   <= '0;
            sclk_prev_reg <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
            cs_n_sync_reg <= {cs_n_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
            dc_sync_reg   <= {dc_sync_reg[SYNC_STAGES-2:0], spi_dc};
            sclk_prev_reg <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            rx_byte_reg    <= '0;
            rx_dc_reg      <= 1'b0;
            byte_valid_reg <= 1'b0;
            abort_reg      <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            abort_reg      <= 1'b0;
            if (shift_en) begin
                shift_reg   <= shift_next;
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    rx_byte_reg    <= shift_next;
                    rx_dc_reg      <= dc_s;
                    byte_valid_reg <= 1'b1;
                end
            end else if (cs_n_s) begin
                // Deselect: a nonzero count means a partial byte is discarded.
                bit_cnt_reg <= '0;
                if (bit_cnt_reg != 3'd0) begin
                    abort_reg <= 1'b1;
                end
            end
        end
    end

    assign rx_byte    = rx_byte_reg;
    assign rx_dc      = rx_dc_reg;
    assign byte_valid = byte_valid_reg;
    assign abort      = abort_reg;

endmodule

// File: rtl/ssd1306_spi_rx.sv
// ssd1306_spi_rx
// SSD1306 4-wire SPI emulation feeding the framebuffer write port.
// Display data bytes are forwarded as {1'b0, byte}; the command stream is
// parsed only to skip argument bytes and to emit SYNC_TOKEN when a
// page-address command (with both arguments) completes.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   spi_*             raw SPI pins
//   din, din_ready    framebuffer write word and its one-cycle strobe
//   data_count        data bytes since last token (saturating)
//   abort             one-cycle pulse on a mid-byte deselect
module ssd1306_spi_rx
    import ssd1306_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_sclk,
    input  logic             spi_mosi,
    input  logic             spi_cs_n,
    input  logic             spi_dc,
    output logic [8:0]       din,
    output logic             din_ready,
    output logic [CNT_W-1:0] data_count,
    output logic             abort
);

    logic [7:0] rx_byte;
    logic       rx_dc;
    logic       byte_valid;

    spi_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte_rx (
        .clk        (clk),
        .reset      (reset),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .spi_dc     (spi_dc),
        .rx_byte    (rx_byte),
        .rx_dc      (rx_dc),
        .byte_valid (byte_valid),
        .abort      (abort)
    );

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    parser_state_t    state_reg,      state_next;
    logic [2:0]       arg_left_reg,   arg_left_next;
    logic             is_page_reg,    is_page_next;
    logic [8:0]       din_reg,        din_next;
    logic             din_ready_reg,  din_ready_next;
    logic [CNT_W-1:0] data_count_reg, data_count_next;
    logic [2:0]       opcode_args;

    assign opcode_args = arg_count(rx_byte);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= CMD;
            arg_left_reg   <= '0;
            is_page_reg    <= 1'b0;
            din_reg        <= '0;
            din_ready_reg  <= 1'b0;
            data_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            arg_left_reg   <= arg_left_next;
            is_page_reg    <= is_page_next;
            din_reg        <= din_next;
            din_ready_reg  <= din_ready_next;
            data_count_reg <= data_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        arg_left_next   = arg_left_reg;
        is_page_next    = is_page_reg;
        din_next        = din_reg;
        din_ready_next  = 1'b0;
        data_count_next = data_count_reg;

        if (byte_valid) begin
            if (rx_dc) begin
                // Data arriving while arguments are still owed is dropped
                // and does not count toward the argument bytes.
                if (state_reg == CMD) begin
                    din_next       = {1'b0, rx_byte};
                    din_ready_next = 1'b1;
                    if (data_count_reg != CNT_MAX) begin
                        data_count_next = data_count_reg + 1'b1;
                    end
                end
            end else begin
                case (state_reg)
                    CMD: begin
                        if (opcode_args != 3'd0) begin
                            arg_left_next = opcode_args;
                            is_page_next  = (rx_byte == CMD_PAGE_ADDR);
                            state_next    = ARG;
                        end
                    end
                    ARG: begin
                        arg_left_next = arg_left_reg - 3'd1;
                        if (arg_left_reg == 3'd1) begin
                            state_next = CMD;
                            if (is_page_reg) begin
                                din_next        = SYNC_TOKEN;
                                din_ready_next  = 1'b1;
                                data_count_next = '0;
                                is_page_next    = 1'b0;
                            end
                        end
                    end
                    default: state_next = CMD;
                endcase
            end
        end
    end

    assign din        = din_reg;
    assign din_ready  = din_ready_reg;
    assign data_count = data_count_reg;

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
module tb_ssd1306_spi_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_dc = 1'b0;
    logic [8:0]  din;
    logic        din_ready;
    logic [10:0] data_count;
    logic        abort;

    ssd1306_spi_rx #(
        .SYNC_STAGES (2),
        .CNT_W       (11)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .spi_dc     (spi_dc),
        .din        (din),
        .din_ready  (din_ready),
        .data_count (data_count),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int error_cnt = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int abort_cnt = 0;
    int dbl_cnt = 0;
    int last_strobe_cyc = 0;
    int rise_cyc = 0;
    int exp_strobes = 0;
    logic [8:0] last_din = '0;
    logic prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (din_ready) begin
            strobe_cnt      = strobe_cnt + 1;
            last_din        = din;
            last_strobe_cyc = cyc;
            if (prev_ready) dbl_cnt = dbl_cnt + 1;
        end
        if (abort) abort_cnt = abort_cnt + 1;
        prev_ready = din_ready;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt = check_cnt + 1;
        if (obs !== exp) begin
            error_cnt = error_cnt + 1;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Sends the top n bits of b, MSB first; sclk low 2 cycles, high 2 cycles.
    task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            spi_mosi = b[i];
            spi_dc   = dc;
            @(negedge clk);
            spi_sclk = 1'b1;
            rise_cyc = cyc;
            @(negedge clk);
            @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        send_bits(b, 8, dc);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check_val("reset_din", {23'd0, din}, 32'h0);
        check_val("reset_din_ready", {31'd0, din_ready}, 32'h0);
        check_val("reset_data_count", {21'd0, data_count}, 32'h0);
        check_val("reset_abort", {31'd0, abort}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single data byte
        spi_cs_n = 1'b0;
        settle();
        send_byte(8'hA5, 1'b1);
        settle();
        exp_strobes = 1;
        check_val("data_strobes", strobe_cnt, exp_strobes);
        check_val("data_din", {23'd0, last_din}, 32'h0A5);
        check_val("data_count_1", {21'd0, data_count}, 32'd1);
        // pin rise + 2 sync stages + byte_valid + din_ready = 4 clk
        check_val("data_latency", last_strobe_cyc - rise_cyc, 32'd4);

        // Page address command -> token after third byte only
        send_byte(8'h22, 1'b0);
        send_byte(8'h00, 1'b0);
        settle();
        check_val("page_no_early_token", strobe_cnt, exp_strobes);
        send_byte(8'h07, 1'b0);
        settle();
        exp_strobes++;
        check_val("page_strobes", strobe_cnt, exp_strobes);
        check_val("page_token", {23'd0, last_din}, 32'h100);
        check_val("page_count_clr", {21'd0, data_count}, 32'd0);

        // Contrast with argument 0x22 must not look like a page command
        send_byte(8'h81, 1'b0);
        send_byte(8'h22, 1'b0);
        settle();
        check_val("contrast_no_token", strobe_cnt, exp_strobes);
        send_byte(8'h11, 1'b1);
        settle();
        exp_strobes++;
        check_val("contrast_data_strobes", strobe_cnt, exp_strobes);
        check_val("contrast_data_din", {23'd0, last_din}, 32'h011);
        check_val("contrast_count", {21'd0, data_count}, 32'd1);

        // Abort: 5 bits then deselect
        send_bits(8'hFF, 5, 1'b1);
        @(negedge clk);
        spi_cs_n = 1'b1;
        settle();
        check_val("abort_pulses", abort_cnt, 32'd1);
        check_val("abort_no_strobe", strobe_cnt, exp_strobes);
        spi_cs_n = 1'b0;
        settle();
        send_byte(8'h3C, 1'b1);
        settle();
        exp_strobes++;
        check_val("post_abort_strobes", strobe_cnt, exp_strobes);
        check_val("post_abort_din", {23'd0, last_din}, 32'h03C);
        check_val("post_abort_count", {21'd0, data_count}, 32'd2);

        // Reset mid-ARG and mid-byte
        send_byte(8'h22, 1'b0);
        send_byte(8'h00, 1'b0);
        send_bits(8'hF0, 3, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_mid_no_strobe", strobe_cnt, exp_strobes);
        check_val("rst_mid_din", {23'd0, din}, 32'h0);
        check_val("rst_mid_count", {21'd0, data_count}, 32'd0);
        settle();
        send_byte(8'hFF, 1'b1);
        settle();
        exp_strobes++;
        check_val("rst_data_strobes", strobe_cnt, exp_strobes);
        check_val("rst_data_din", {23'd0, last_din}, 32'h0FF);
        check_val("rst_data_count", {21'd0, data_count}, 32'd1);
        check_val("rst_abort_none", abort_cnt, 32'd1);

        // Saturation: count is 1, 2050 more bytes pass 2047
        for (int i = 0; i < 2050; i++) begin
            send_byte(i[7:0], 1'b1);
        end
        settle();
        exp_strobes += 2050;
        check_val("sat_strobes", strobe_cnt, exp_strobes);
        check_val("sat_last_din", {23'd0, last_din}, 32'h001);
        check_val("sat_count", {21'd0, data_count}, 32'd2047);
        send_byte(8'h22, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h07, 1'b0);
        settle();
        exp_strobes++;
        check_val("sat_token_strobes", strobe_cnt, exp_strobes);
        check_val("sat_token_din", {23'd0, last_din}, 32'h100);
        check_val("sat_token_count", {21'd0, data_count}, 32'd0);
        check_val("single_cycle_strobes", dbl_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
